keypad_debounce_encoder: RTL and testbench
==========================================

Name: keypad_debounce_encoder

Overview:
- Parametrised, clocked successor to the microwave's combinational keypad priority encoder.
- Synchronises and debounces a one-hot-ish key vector, then priority-encodes it to a binary code.
- Emits exactly one active-low load strobe per debounced press, and re-arms only after a debounced release.
- Sits between the raw keypad pins and the time-entry digit counter, which consumes saidaBCD on loadn low.

Parameters:
- NUM_KEYS, 10, number of key inputs; key i encodes to value i.
- CODE_W, 4, width of saidaBCD; must satisfy 2^CODE_W >= NUM_KEYS.
- DEBOUNCE_CYCLES, 4, count of stable-sample cycles required on press and on release; legal range 1..255.
- PRIORITY_HIGH, 1, 1 = highest asserted index wins; 0 = lowest asserted index wins.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- teclado  in  NUM_KEYS  raw asynchronous key lines, active high.
- enablen  in  1  active-low enable; high blocks new presses.
- saidaBCD  out  CODE_W  code of the last accepted key (registered).
- loadn  out  1  active-low one-cycle strobe: saidaBCD is newly valid.
- busy  out  1  high whenever FSM is not IDLE.
- multi  out  1  registered; high while more than one bit of the synchronised vector is set.

Behaviour:
- Reset (reset=1 at an edge):
  - state=IDLE, cnt=0, both sync stages cleared, candidate code cleared.
  - saidaBCD=0, loadn=1, busy=0, multi=0.
  - Reset mid-press or mid-release aborts with no strobe.
- Synchroniser: two flops, s1<=teclado, s2<=s1. All decisions use s2 only.
  - any = OR of s2.
  - enc = priority encode of s2 per PRIORITY_HIGH; enc=0 when any=0.
- cnt is 8 bits; candidate is CODE_W bits.
- FSM states and transitions:
  - IDLE:
    - enablen=0 and any=1 -> DEBOUNCE, candidate<=enc, cnt<=1.
    - Otherwise stay.
  - DEBOUNCE:
    - enablen=1 or any=0 -> IDLE (no strobe).
    - enc != candidate -> stay, candidate<=enc, cnt<=1 (restart).
    - Stable and cnt==DEBOUNCE_CYCLES -> PRESSED; at that same edge saidaBCD<=candidate and loadn<=0.
    - Stable and cnt<DEBOUNCE_CYCLES -> cnt<=cnt+1.
  - PRESSED:
    - loadn returns to 1 on the next edge (strobe is exactly one cycle).
    - Key rollover or extra keys while held are ignored; saidaBCD holds.
    - any=0 -> RELEASE, cnt<=1.
    - enablen=1 -> IDLE.
  - RELEASE:
    - any=1 -> PRESSED, no new strobe (bounce on release).
    - any=0 and cnt==DEBOUNCE_CYCLES -> IDLE.
    - any=0 and cnt<DEBOUNCE_CYCLES -> cnt<=cnt+1.
    - enablen=1 -> IDLE.
- Latency: with teclado stable from the edge that loads s1 (edge 0), loadn is driven low by edge DEBOUNCE_CYCLES+2 and stays low for one cycle (DEBOUNCE_CYCLES=4: low after edge 6).
- enablen=1 at any time:
  - Forces IDLE at the next edge and cancels any pending strobe.
  - saidaBCD holds its last value.
  - loadn is never low while enablen was 1 at the deciding edge.
  - A key still held when enablen returns to 0 is debounced afresh and yields one strobe.
- All-zero input never produces a strobe; code 0 is only output for a real key-0 press.
- busy = (state != IDLE), registered alongside state.
- multi is updated every cycle from s2, independent of state and enablen; cleared only by reset or by s2 dropping to 0 or 1 bits set.

Test Plan:
- Reset then key 7 (teclado=0x080) held 20 cycles, enablen=0, defaults -> single loadn low pulse after edge 6, saidaBCD=7, busy high until 5 cycles after release.
- Keys 2 and 9 together (0x204) -> saidaBCD=9, multi=1; same stimulus with PRIORITY_HIGH=0 -> saidaBCD=2.
- Key 5 bouncing (toggle every 2 cycles for 10 cycles, then stable) -> exactly one strobe, saidaBCD=5, strobe edge = last toggle + DEBOUNCE_CYCLES+2.
- Key 3 press, release bounce (0/1 alternating 3 cycles) then release -> one strobe total; second clean press of 3 -> second strobe.
- enablen=1 while key 4 held -> no strobe, saidaBCD keeps prior value; enablen->0 with key still held -> one strobe, saidaBCD=4.
- reset asserted during DEBOUNCE of key 6 -> loadn stays 1, saidaBCD=0; NUM_KEYS=16, CODE_W=4: key 15 -> saidaBCD=15.

Source files
------------

// File: rtl/keypad_debounce_encoder_if.sv
// Keypad-side bundle for keypad_debounce_encoder.
// The master drives the raw key lines and the enable. The slave (the encoder) returns
// the code, the load strobe and the status flags.
interface keypad_debounce_encoder_if #(
    parameter int NUM_KEYS = 10,
    parameter int CODE_W   = 4
);
    logic [NUM_KEYS-1:0] teclado;
    logic                enablen;
    logic [CODE_W-1:0]   saidaBCD;
    logic                loadn;
    logic                busy;
    logic                multi;

    modport master (
        output teclado,
        output enablen,
        input  saidaBCD,
        input  loadn,
        input  busy,
        input  multi
    );

    modport slave (
        input  teclado,
        input  enablen,
        output saidaBCD,
        output loadn,
        output busy,
        output multi
    );
endinterface

// File: rtl/keypad_debounce_encoder.sv
// Clocked keypad front end.
// - Synchronises the raw key lines and debounces both press and release.
// - Priority-encodes the synchronised vector.
// - Emits one active-low load strobe for each accepted press.
// - Re-arms only after a debounced release, or after enablen has forced the FSM idle.
module keypad_debounce_encoder #(
    parameter int NUM_KEYS        = 10,
    parameter int CODE_W          = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PRIORITY_HIGH   = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    keypad_debounce_encoder_if.slave  kp
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    localparam logic [7:0] DC_LIMIT = 8'(DEBOUNCE_CYCLES);

    // True when two or more bits of the vector are set: clearing the lowest set bit leaves something.
    function automatic logic more_than_one(input logic [NUM_KEYS-1:0] v);
        return ((v & (v - {{(NUM_KEYS-1){1'b0}}, 1'b1})) != {NUM_KEYS{1'b0}});
    endfunction

    logic [NUM_KEYS-1:0] s1_q;
    logic [NUM_KEYS-1:0] s2_q;
    logic                any_s;
    logic [CODE_W-1:0]   enc_s;

    state_t              state_q;
    state_t              state_d;
    logic [7:0]          cnt_q;
    logic [7:0]          cnt_d;
    logic [CODE_W-1:0]   cand_q;
    logic [CODE_W-1:0]   cand_d;

    logic [CODE_W-1:0]   code_q;
    logic [CODE_W-1:0]   code_d;
    logic                loadn_q;
    logic                loadn_d;
    logic                busy_q;
    logic                busy_d;
    logic                multi_q;
    logic                multi_d;

    // Two-flop synchroniser; every decision below looks only at s2_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q <= {NUM_KEYS{1'b0}};
            s2_q <= {NUM_KEYS{1'b0}};
        end else begin
            s1_q <= kp.teclado;
            s2_q <= s1_q;
        end
    end

    // Priority encoder: a later match in the scan overrides an earlier one, so the scan direction sets the winner.
    always_comb begin
        any_s = (s2_q != {NUM_KEYS{1'b0}});
        enc_s = {CODE_W{1'b0}};
        if (PRIORITY_HIGH != 0) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                enc_s = s2_q[i] ? CODE_W'(i) : enc_s;
            end
        end else begin
            for (int i = NUM_KEYS - 1; i >= 0; i--) begin
                enc_s = s2_q[i] ? CODE_W'(i) : enc_s;
            end
        end
    end

    // FSM state register together with the debounce counter and candidate code.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            cand_q  <= {CODE_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
        end
    end

    // Next-state logic. enablen high always wins and drops the FSM back to idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        case (state_q)
            ST_IDLE: begin
                if (!kp.enablen && any_s) begin
                    state_d = ST_DEBOUNCE;
                    cand_d  = enc_s;
                    cnt_d   = 8'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DEBOUNCE: begin
                if (kp.enablen || !any_s) begin
                    state_d = ST_IDLE;
                end else if (enc_s != cand_q) begin
                    cand_d = enc_s;
                    cnt_d  = 8'd1;
                end else if (cnt_q >= DC_LIMIT) begin
                    state_d = ST_PRESSED;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_PRESSED: begin
                if (kp.enablen) begin
                    state_d = ST_IDLE;
                end else if (!any_s) begin
                    state_d = ST_RELEASE;
                    cnt_d   = 8'd1;
                end else begin
                    state_d = ST_PRESSED;
                end
            end
            ST_RELEASE: begin
                if (kp.enablen) begin
                    state_d = ST_IDLE;
                end else if (any_s) begin
                    state_d = ST_PRESSED;
                end else if (cnt_q >= DC_LIMIT) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
                cand_d  = {CODE_W{1'b0}};
            end
        endcase
    end

    // Output decode. The strobe fires only on the debounce-to-pressed transition, which also latches the code.
    always_comb begin
        code_d  = code_q;
        loadn_d = 1'b1;
        busy_d  = (state_d != ST_IDLE);
        multi_d = more_than_one(s2_q);
        if ((state_q == ST_DEBOUNCE) && (state_d == ST_PRESSED)) begin
            code_d  = cand_q;
            loadn_d = 1'b0;
        end else begin
            code_d  = code_q;
            loadn_d = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            code_q  <= {CODE_W{1'b0}};
            loadn_q <= 1'b1;
            busy_q  <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            code_q  <= code_d;
            loadn_q <= loadn_d;
            busy_q  <= busy_d;
            multi_q <= multi_d;
        end
    end

    assign kp.saidaBCD = code_q;
    assign kp.loadn    = loadn_q;
    assign kp.busy     = busy_q;
    assign kp.multi    = multi_q;

endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Bench for keypad_debounce_encoder.
// Three instances share the same clock, reset and stimulus:
//   dut0 = default configuration,
//   dut1 = lowest index wins,
//   dut2 = 16 keys with a debounce length of 1.
// A run-length reference model predicts every output of every instance on every cycle.
module tb_keypad_debounce_encoder;

    localparam int NI = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] tk;
    logic        en;

    int cfg_dc [NI] = '{4, 4, 1};
    int cfg_nk [NI] = '{10, 10, 16};
    bit cfg_ph [NI] = '{1'b1, 1'b0, 1'b1};

    int pass_cnt  = 0;
    int total_cnt = 0;
    int sidx;
    int strobe_cnt  [NI];
    int strobe_at   [NI];
    int busy_low_at [NI];

    // Reference model state
    logic [15:0] m_s1    [NI];
    logic [15:0] m_s2    [NI];
    bit          m_held  [NI];
    int          m_run   [NI];
    int          m_rel   [NI];
    logic [3:0]  m_cand  [NI];
    logic [3:0]  m_code  [NI];
    bit          m_loadn [NI];
    bit          m_busy  [NI];
    bit          m_multi [NI];

    always #5 clock = ~clock;

    keypad_debounce_encoder_if #(.NUM_KEYS(10), .CODE_W(4)) if0 ();
    keypad_debounce_encoder_if #(.NUM_KEYS(10), .CODE_W(4)) if1 ();
    keypad_debounce_encoder_if #(.NUM_KEYS(16), .CODE_W(4)) if2 ();

    assign if0.teclado = tk[9:0];
    assign if1.teclado = tk[9:0];
    assign if2.teclado = tk;
    assign if0.enablen = en;
    assign if1.enablen = en;
    assign if2.enablen = en;

    keypad_debounce_encoder #(.NUM_KEYS(10), .CODE_W(4), .DEBOUNCE_CYCLES(4), .PRIORITY_HIGH(1)) dut0 (
        .clock(clock), .reset(reset), .kp(if0));
    keypad_debounce_encoder #(.NUM_KEYS(10), .CODE_W(4), .DEBOUNCE_CYCLES(4), .PRIORITY_HIGH(0)) dut1 (
        .clock(clock), .reset(reset), .kp(if1));
    keypad_debounce_encoder #(.NUM_KEYS(16), .CODE_W(4), .DEBOUNCE_CYCLES(1), .PRIORITY_HIGH(1)) dut2 (
        .clock(clock), .reset(reset), .kp(if2));

    wire [6:0] obs0 = {if0.saidaBCD, if0.loadn, if0.busy, if0.multi};
    wire [6:0] obs1 = {if1.saidaBCD, if1.loadn, if1.busy, if1.multi};
    wire [6:0] obs2 = {if2.saidaBCD, if2.loadn, if2.busy, if2.multi};

    function automatic logic [6:0] get_obs(int n);
        case (n)
            0:       return obs0;
            1:       return obs1;
            default: return obs2;
        endcase
    endfunction

    function automatic logic [6:0] exp_obs(int n);
        return {m_code[n], m_loadn[n], m_busy[n], m_multi[n]};
    endfunction

    function automatic logic [3:0] ref_enc(logic [15:0] v, bit ph);
        if (ph) begin
            for (int i = 15; i >= 0; i--) begin
                if (v[i]) return 4'(i);
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (v[i]) return 4'(i);
            end
        end
        return 4'd0;
    endfunction

    // Model view of the design:
    // - A press is accepted once the same nonzero code has been seen, enabled, on
    //   DEBOUNCE_CYCLES+1 consecutive decision edges.
    // - A held key is let go once the vector has been empty, enabled, on
    //   DEBOUNCE_CYCLES+1 consecutive edges.
    task automatic model_edge();
        for (int n = 0; n < NI; n++) begin
            logic [15:0] v;
            logic [15:0] mask;
            bit          any;
            logic [3:0]  e;
            v    = m_s2[n];
            mask = 16'((32'd1 << cfg_nk[n]) - 32'd1);
            any  = (v != 16'd0);
            e    = ref_enc(v, cfg_ph[n]);
            if (reset) begin
                m_s1[n] = 16'd0; m_s2[n] = 16'd0;
                m_held[n] = 1'b0; m_run[n] = 0; m_rel[n] = 0;
                m_cand[n] = 4'd0; m_code[n] = 4'd0;
                m_loadn[n] = 1'b1; m_busy[n] = 1'b0; m_multi[n] = 1'b0;
            end else begin
                m_multi[n] = ($countones(v) > 1);
                m_loadn[n] = 1'b1;
                if (en) begin
                    m_held[n] = 1'b0; m_run[n] = 0; m_rel[n] = 0;
                end else if (!m_held[n]) begin
                    if (!any) m_run[n] = 0;
                    else if (m_run[n] > 0 && e == m_cand[n]) m_run[n]++;
                    else begin m_run[n] = 1; m_cand[n] = e; end
                    if (m_run[n] == cfg_dc[n] + 1) begin
                        m_code[n] = m_cand[n]; m_loadn[n] = 1'b0;
                        m_held[n] = 1'b1; m_run[n] = 0; m_rel[n] = 0;
                    end
                end else begin
                    if (any) m_rel[n] = 0;
                    else begin
                        m_rel[n]++;
                        if (m_rel[n] == cfg_dc[n] + 1) begin m_held[n] = 1'b0; m_rel[n] = 0; end
                    end
                end
                m_busy[n] = m_held[n] || (m_run[n] > 0);
                m_s2[n]   = m_s1[n];
                m_s1[n]   = tk & mask;
            end
        end
    endtask

    // One clock: update the model at the edge, then sample the DUTs 1 time unit later.
    task automatic step();
        logic [6:0] o;
        @(posedge clock);
        model_edge();
        #1;
        for (int n = 0; n < NI; n++) begin
            o = get_obs(n);
            if (o[2] == 1'b0) begin strobe_cnt[n]++; strobe_at[n] = sidx; end
            if (o[1] == 1'b0 && busy_low_at[n] < 0) busy_low_at[n] = sidx;
        end
        sidx++;
    endtask

    task automatic clear_marks();
        sidx = 0;
        for (int n = 0; n < NI; n++) begin
            strobe_cnt[n] = 0; strobe_at[n] = -1; busy_low_at[n] = -1;
        end
    endtask

    task automatic test_reset();
        logic [6:0] o;
        reset = 1'b1; tk = 16'd0; en = 1'b0;
        clear_marks();
        for (int c = 0; c < 3; c++) begin
            step();
            for (int n = 0; n < NI; n++) begin
                total_cnt++;
                if (get_obs(n) !== exp_obs(n)) $display("FAIL reset_model dut%0d got %b exp %b", n, get_obs(n), exp_obs(n));
                else pass_cnt++;
            end
        end
        reset = 1'b0;
        o = get_obs(0);
        total_cnt++;
        if (o !== 7'b0000_1_0_0) $display("FAIL reset_state got %b exp 0000100", o);
        else pass_cnt++;
    endtask

    task automatic test_key7();
        logic [6:0] o;
        clear_marks();
        tk = 16'h0080;
        for (int c = 0; c < 20; c++) begin
            step();
            for (int n = 0; n < NI; n++) begin
                total_cnt++;
                if (get_obs(n) !== exp_obs(n)) $display("FAIL key7 dut%0d edge%0d got %b exp %b", n, sidx - 1, get_obs(n), exp_obs(n));
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (strobe_cnt[0] !== 1 || strobe_at[0] !== 6) $display("FAIL key7_strobe got cnt %0d at %0d exp cnt 1 at 6", strobe_cnt[0], strobe_at[0]);
        else pass_cnt++;
        total_cnt++;
        if (strobe_at[2] !== 3) $display("FAIL key7_strobe_dc1 got %0d exp 3", strobe_at[2]);
        else pass_cnt++;
        o = get_obs(0);
        total_cnt++;
        if (o[6:3] !== 4'd7 || o[1] !== 1'b1) $display("FAIL key7_code got %0d busy %b exp 7 busy 1", o[6:3], o[1]);
        else pass_cnt++;
        clear_marks();
        tk = 16'h0000;
        for (int c = 0; c < 10; c++) begin
            step();
            for (int n = 0; n < NI; n++) begin
                total_cnt++;
                if (get_obs(n) !== exp_obs(n)) $display("FAIL key7_rel dut%0d edge%0d got %b exp %b", n, sidx - 1, get_obs(n), exp_obs(n));
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (busy_low_at[0] !== 6 || busy_low_at[2] !== 3) $display("FAIL key7_busy_fall got %0d/%0d exp 6/3", busy_low_at[0], busy_low_at[2]);
        else pass_cnt++;
    endtask

    task automatic test_multi();
        logic [6:0] o0;
        logic [6:0] o1;
        clear_marks();
        tk = 16'h0204;
        for (int c = 0; c < 12; c++) begin
            step();
            for (int n = 0; n < NI; n++) begin
                total_cnt++;
                if (get_obs(n) !== exp_obs(n)) $display("FAIL multi dut%0d edge%0d got %b exp %b", n, sidx - 1, get_obs(n), exp_obs(n));
                else pass_cnt++;
            end
        end
        o0 = get_obs(0);
        o1 = get_obs(1);
        total_cnt++;
        if (o0[6:3] !== 4'd9 || o0[0] !== 1'b1) $display("FAIL multi_high got code %0d multi %b exp 9 1", o0[6:3], o0[0]);
        else pass_cnt++;
        total_cnt++;
        if (o1[6:3] !== 4'd2 || o1[0] !== 1'b1) $display("FAIL multi_low got code %0d multi %b exp 2 1", o1[6:3], o1[0]);
        else pass_cnt++;
        tk = 16'h0000;
        for (int c = 0; c < 10; c++) begin
            step();
            for (int n = 0; n < NI; n++) begin
                total_cnt++;
                if (get_obs(n) !== exp_obs(n)) $display("FAIL multi_rel dut%0d edge%0d got %b exp %b", n, sidx - 1, get_obs(n), exp_obs(n));
                else pass_cnt++;
            end
        end
        o0 = get_obs(0);
        total_cnt++;
        if (o0[0] !== 1'b0 || strobe_cnt[0] !== 1) $display("FAIL multi_clear got multi %b strobes %0d exp 0 1", o0[0], strobe_cnt[0]);
        else pass_cnt++;
    endtask

    task automatic test_bounce();
        logic [6:0] o;
        clear_marks();
        for (int c = 0; c < 26; c++) begin
            if (c < 10) tk = (((c / 2) % 2) == 0) ? 16'h0020 : 16'h0000;
            else tk = 16'h0020;
            step();
            for (int n = 0; n < NI; n++) begin
                total_cnt++;
                if (get_obs(n) !== exp_obs(n)) $display("FAIL bounce dut%0d edge%0d got %b exp %b", n, sidx - 1, get_obs(n), exp_obs(n));
                else pass_cnt++;
            end
        end
        o = get_obs(0);
        total_cnt++;
        if (strobe_cnt[0] !== 1 || strobe_at[0] !== 14 || o[6:3] !== 4'd5)
            $display("FAIL bounce_strobe got cnt %0d at %0d code %0d exp 1 at 14 code 5", strobe_cnt[0], strobe_at[0], o[6:3]);
        else pass_cnt++;
        tk = 16'h0000;
        for (int c = 0; c < 10; c++) begin
            step();
            for (int n = 0; n < NI; n++) begin
                total_cnt++;
                if (get_obs(n) !== exp_obs(n)) $display("FAIL bounce_rel dut%0d edge%0d got %b exp %b", n, sidx - 1, get_obs(n), exp_obs(n));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_release_bounce();
        logic [15:0] pat [47];
        logic [6:0]  o;
        for (int c = 0; c < 47; c++) begin
            if (c < 12) pat[c] = 16'h0008;
            else if (c < 15) pat[c] = (c == 13) ? 16'h0008 : 16'h0000;
            else if (c < 25) pat[c] = 16'h0000;
            else if (c < 37) pat[c] = 16'h0008;
            else pat[c] = 16'h0000;
        end
        clear_marks();
        for (int c = 0; c < 47; c++) begin
            tk = pat[c];
            step();
            for (int n = 0; n < NI; n++) begin
                total_cnt++;
                if (get_obs(n) !== exp_obs(n)) $display("FAIL relbounce dut%0d edge%0d got %b exp %b", n, sidx - 1, get_obs(n), exp_obs(n));
                else pass_cnt++;
            end
        end
        o = get_obs(0);
        total_cnt++;
        if (strobe_cnt[0] !== 2 || strobe_cnt[2] !== 2 || o[6:3] !== 4'd3)
            $display("FAIL relbounce_count got %0d/%0d code %0d exp 2/2 code 3", strobe_cnt[0], strobe_cnt[2], o[6:3]);
        else pass_cnt++;
    endtask

    task automatic test_enable();
        logic [6:0] o;
        clear_marks();
        en = 1'b1;
        tk = 16'h0010;
        for (int c = 0; c < 12; c++) begin
            step();
            for (int n = 0; n < NI; n++) begin
                total_cnt++;
                if (get_obs(n) !== exp_obs(n)) $display("FAIL enable_blk dut%0d edge%0d got %b exp %b", n, sidx - 1, get_obs(n), exp_obs(n));
                else pass_cnt++;
            end
        end
        o = get_obs(0);
        total_cnt++;
        if (strobe_cnt[0] !== 0 || strobe_cnt[2] !== 0 || o[6:3] !== 4'd3)
            $display("FAIL enable_block got strobes %0d/%0d code %0d exp 0/0 code 3", strobe_cnt[0], strobe_cnt[2], o[6:3]);
        else pass_cnt++;
        clear_marks();
        en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            for (int n = 0; n < NI; n++) begin
                total_cnt++;
                if (get_obs(n) !== exp_obs(n)) $display("FAIL enable_on dut%0d edge%0d got %b exp %b", n, sidx - 1, get_obs(n), exp_obs(n));
                else pass_cnt++;
            end
        end
        o = get_obs(0);
        total_cnt++;
        if (strobe_cnt[0] !== 1 || strobe_at[0] !== 4 || strobe_at[2] !== 1 || o[6:3] !== 4'd4)
            $display("FAIL enable_resume got cnt %0d at %0d/%0d code %0d exp 1 at 4/1 code 4", strobe_cnt[0], strobe_at[0], strobe_at[2], o[6:3]);
        else pass_cnt++;
        tk = 16'h0000;
        for (int c = 0; c < 10; c++) begin
            step();
            for (int n = 0; n < NI; n++) begin
                total_cnt++;
                if (get_obs(n) !== exp_obs(n)) $display("FAIL enable_rel dut%0d edge%0d got %b exp %b", n, sidx - 1, get_obs(n), exp_obs(n));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] o;
        clear_marks();
        tk = 16'h0040;
        for (int c = 0; c < 15; c++) begin
            if (c == 4) begin reset = 1'b1; tk = 16'h0000; end
            else if (c == 5) reset = 1'b0;
            step();
            for (int n = 0; n < NI; n++) begin
                total_cnt++;
                if (get_obs(n) !== exp_obs(n)) $display("FAIL rstmid dut%0d edge%0d got %b exp %b", n, sidx - 1, get_obs(n), exp_obs(n));
                else pass_cnt++;
            end
        end
        o = get_obs(0);
        total_cnt++;
        if (strobe_cnt[0] !== 0 || strobe_cnt[1] !== 0 || o[6:3] !== 4'd0 || o[2] !== 1'b1)
            $display("FAIL rstmid_abort got strobes %0d/%0d code %0d loadn %b exp 0/0 code 0 loadn 1", strobe_cnt[0], strobe_cnt[1], o[6:3], o[2]);
        else pass_cnt++;
    endtask

    task automatic test_key15();
        logic [6:0] o0;
        logic [6:0] o2;
        clear_marks();
        tk = 16'h8000;
        for (int c = 0; c < 8; c++) begin
            step();
            for (int n = 0; n < NI; n++) begin
                total_cnt++;
                if (get_obs(n) !== exp_obs(n)) $display("FAIL key15 dut%0d edge%0d got %b exp %b", n, sidx - 1, get_obs(n), exp_obs(n));
                else pass_cnt++;
            end
        end
        o0 = get_obs(0);
        o2 = get_obs(2);
        total_cnt++;
        if (o2[6:3] !== 4'd15 || strobe_cnt[2] !== 1 || strobe_at[2] !== 3)
            $display("FAIL key15_code got %0d cnt %0d at %0d exp 15 1 at 3", o2[6:3], strobe_cnt[2], strobe_at[2]);
        else pass_cnt++;
        total_cnt++;
        if (strobe_cnt[0] !== 0 || o0[6:3] !== 4'd0) $display("FAIL key15_narrow got %0d code %0d exp 0 code 0", strobe_cnt[0], o0[6:3]);
        else pass_cnt++;
        tk = 16'h0000;
        for (int c = 0; c < 6; c++) begin
            step();
            for (int n = 0; n < NI; n++) begin
                total_cnt++;
                if (get_obs(n) !== exp_obs(n)) $display("FAIL key15_rel dut%0d edge%0d got %b exp %b", n, sidx - 1, get_obs(n), exp_obs(n));
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_random();
        int cyc;
        int len;
        int kind;
        cyc = 0;
        clear_marks();
        while (cyc < 3000) begin
            len  = $urandom_range(1, 12);
            kind = $urandom_range(0, 9);
            if (kind < 3) tk = 16'h0000;
            else if (kind < 7) tk = 16'd1 << $urandom_range(0, 15);
            else if (kind < 9) tk = 16'($urandom);
            else tk = tk;
            en    = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 49) == 0);
            for (int c = 0; c < len; c++) begin
                step();
                reset = 1'b0;
                cyc++;
                for (int n = 0; n < NI; n++) begin
                    total_cnt++;
                    if (get_obs(n) !== exp_obs(n)) $display("FAIL random dut%0d cyc%0d got %b exp %b", n, cyc, get_obs(n), exp_obs(n));
                    else pass_cnt++;
                end
            end
        end
        en = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        tk    = 16'h0000;
        en    = 1'b0;
        for (int n = 0; n < NI; n++) begin
            m_s1[n] = 16'd0; m_s2[n] = 16'd0; m_held[n] = 1'b0; m_run[n] = 0; m_rel[n] = 0;
            m_cand[n] = 4'd0; m_code[n] = 4'd0; m_loadn[n] = 1'b1; m_busy[n] = 1'b0; m_multi[n] = 1'b0;
        end
        test_reset();
        test_key7();
        test_multi();
        test_bounce();
        test_release_bounce();
        test_enable();
        test_reset_mid();
        test_key15();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
